// File: rtl/bxu_io_pkg.sv
// bxu_io_pkg
//   Shared definitions for the BXU op I/O channel block: FSM state encodings,
//   completion error codes, the default data width and a channel range helper.
//   No ports (package).

package bxu_io_pkg;

    localparam int DATA_BITWIDTH_DFLT = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_IN_WAIT  = 2'd1;
    localparam logic [1:0] ST_OUT_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic [1:0] IO_ERR_NONE    = 2'd0;
    localparam logic [1:0] IO_ERR_BAD_CH  = 2'd1;
    localparam logic [1:0] IO_ERR_TIMEOUT = 2'd2;

    function automatic logic ch_legal(input int unsigned ch, input int unsigned ch_num);
        return ch < ch_num;
    endfunction

endpackage

// File: rtl/op_io_chsel.sv
// op_io_chsel
//   Channel select for op_io_chan: one-hot decode of the latched channel index
//   into the per-channel ready/valid vectors, plus the input word mux and the
//   handshake-complete flags for the selected channel.
// Ports
//   ch            in   latched channel index (always < CH_NUM when enabled)
//   in_en/out_en  in   FSM is in the input / output wait state
//   io_in_data    in   packed per-channel input words
//   io_in_valid   in   per-channel input valid
//   io_out_ready  in   per-channel output ready
//   io_in_ready   out  per-channel input ready, one-hot or zero
//   io_out_valid  out  per-channel output valid, one-hot or zero
//   in_word       out  input word of the selected channel
//   in_fire       out  input handshake on the selected channel this cycle
//   out_fire      out  output handshake on the selected channel this cycle

module op_io_chsel
    import bxu_io_pkg::*;
#(
    parameter int DATA_BITWIDTH = DATA_BITWIDTH_DFLT,
    parameter int CH_NUM        = 4,
    parameter int CH_BITWIDTH   = 2
) (
    input  logic [CH_BITWIDTH-1:0]          ch,
    input  logic                            in_en,
    input  logic                            out_en,
    input  logic [CH_NUM*DATA_BITWIDTH-1:0] io_in_data,
    input  logic [CH_NUM-1:0]               io_in_valid,
    input  logic [CH_NUM-1:0]               io_out_ready,
    output logic [CH_NUM-1:0]               io_in_ready,
    output logic [CH_NUM-1:0]               io_out_valid,
    output logic [DATA_BITWIDTH-1:0]        in_word,
    output logic                            in_fire,
    output logic                            out_fire
);

    logic [CH_NUM-1:0] sel;

    always_comb begin
        sel     = '0;
        in_word = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (32'(ch) == k) begin
                sel[k]  = 1'b1;
                in_word = io_in_data[k*DATA_BITWIDTH +: DATA_BITWIDTH];
            end
        end
    end

    // Driven from FSM state only; the peer's valid/ready never reaches these.
    assign io_in_ready  = in_en  ? sel : '0;
    assign io_out_valid = out_en ? sel : '0;

    assign in_fire  = |(io_in_valid  & io_in_ready);
    assign out_fire = |(io_out_ready & io_out_valid);

endmodule

// File: rtl/op_io_chan.sv
// op_io_chan
//   Multi-channel blocking I/O port for the BXU op datapath. One op = one
//   valid/ready handshake on channel op_ch, completed by a one-cycle op_done.
//   Optional wait-state timeout: define BXU_IO_TIMEOUT_EN.
// Ports
//   clk, rst_n            core clock, synchronous active-low reset
//   op_in_req/op_out_req  read / write request (read wins when both high)
//   op_ch, op_wdata       channel index and write word, sampled with request
//   op_rdata              read word, valid with op_done and held after
//   op_done/op_busy       completion pulse / transaction in progress
//   op_err                aborted or illegal op, qualified by op_done
//   io_in_*               per-channel input stream (data packed by channel)
//   io_out_*              shared output word, per-channel valid/ready
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | waiting for a request
//   IN_WAIT  | io_in_ready[ch] high, waiting for io_in_valid
//   OUT_WAIT | io_out_valid[ch] high, waiting for io_out_ready
//   DONE     | op_done pulse, back to IDLE next cycle

module op_io_chan
    import bxu_io_pkg::*;
#(
    parameter int DATA_BITWIDTH  = DATA_BITWIDTH_DFLT,
    parameter int CH_NUM         = 4,
    parameter int CH_BITWIDTH    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            op_in_req,
    input  logic                            op_out_req,
    input  logic [CH_BITWIDTH-1:0]          op_ch,
    input  logic [DATA_BITWIDTH-1:0]        op_wdata,
    output logic [DATA_BITWIDTH-1:0]        op_rdata,
    output logic                            op_done,
    output logic                            op_busy,
    output logic                            op_err,
    input  logic [CH_NUM*DATA_BITWIDTH-1:0] io_in_data,
    input  logic [CH_NUM-1:0]               io_in_valid,
    output logic [CH_NUM-1:0]               io_in_ready,
    output logic [DATA_BITWIDTH-1:0]        io_out_data,
    output logic [CH_NUM-1:0]               io_out_valid,
    input  logic [CH_NUM-1:0]               io_out_ready
);

    logic [1:0]               state_q, state_d;
    logic [CH_BITWIDTH-1:0]   ch_q, ch_d;
    logic [DATA_BITWIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_BITWIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]               err_q, err_d;

    logic                     in_en, out_en, in_fire, out_fire;
    logic [DATA_BITWIDTH-1:0] in_word;
    logic                     ch_ok;

`ifdef BXU_IO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo;
    assign tmo = (cnt_q == CNT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 1);
`endif

    assign in_en  = (state_q == ST_IN_WAIT);
    assign out_en = (state_q == ST_OUT_WAIT);
    assign ch_ok  = ch_legal(32'(op_ch), CH_NUM);

    op_io_chsel #(
        .DATA_BITWIDTH (DATA_BITWIDTH),
        .CH_NUM        (CH_NUM),
        .CH_BITWIDTH   (CH_BITWIDTH)
    ) u_chsel (
        .ch           (ch_q),
        .in_en        (in_en),
        .out_en       (out_en),
        .io_in_data   (io_in_data),
        .io_in_valid  (io_in_valid),
        .io_out_ready (io_out_ready),
        .io_in_ready  (io_in_ready),
        .io_out_valid (io_out_valid),
        .in_word      (in_word),
        .in_fire      (in_fire),
        .out_fire     (out_fire)
    );

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        rdata_d    = rdata_q;
        out_data_d = out_data_q;
        err_d      = err_q;
`ifdef BXU_IO_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_in_req || op_out_req) begin
`ifdef BXU_IO_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (!ch_ok) begin
                        // Illegal channel: complete at once, no channel or output word touched.
                        state_d = ST_DONE;
                        rdata_d = '0;
                        err_d   = IO_ERR_BAD_CH;
                    end else begin
                        ch_d  = op_ch;
                        err_d = IO_ERR_NONE;
                        if (op_in_req) begin
                            state_d = ST_IN_WAIT;
                        end else begin
                            state_d    = ST_OUT_WAIT;
                            out_data_d = op_wdata;
                        end
                    end
                end
            end
            ST_IN_WAIT: begin
                if (in_fire) begin
                    rdata_d = in_word;
                    state_d = ST_DONE;
                end
`ifdef BXU_IO_TIMEOUT_EN
                else if (tmo) begin
                    rdata_d = '0;
                    err_d   = IO_ERR_TIMEOUT;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_OUT_WAIT: begin
                if (out_fire) begin
                    state_d = ST_DONE;
                end
`ifdef BXU_IO_TIMEOUT_EN
                else if (tmo) begin
                    rdata_d = '0;
                    err_d   = IO_ERR_TIMEOUT;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            rdata_q    <= '0;
            out_data_q <= '0;
            err_q      <= IO_ERR_NONE;
`ifdef BXU_IO_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            rdata_q    <= rdata_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
`ifdef BXU_IO_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign op_rdata    = rdata_q;
    assign io_out_data = out_data_q;
    assign op_done     = (state_q == ST_DONE);
    assign op_busy     = (state_q != ST_IDLE);
    assign op_err      = op_done && (err_q != IO_ERR_NONE);

endmodule

// File: tb/tb_op_io_chan.sv
module tb_op_io_chan;

    localparam int DW  = 8;
    localparam int CHN = 3;
    localparam int CHW = 2;
    localparam int TO  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           op_in_req = 1'b0;
    logic           op_out_req = 1'b0;
    logic [CHW-1:0] op_ch = '0;
    logic [DW-1:0]  op_wdata = '0;
    logic [DW-1:0]  op_rdata;
    logic           op_done, op_busy, op_err;
    logic [CHN*DW-1:0] io_in_data = '0;
    logic [CHN-1:0] io_in_valid = '0;
    logic [CHN-1:0] io_in_ready;
    logic [DW-1:0]  io_out_data;
    logic [CHN-1:0] io_out_valid;
    logic [CHN-1:0] io_out_ready = '0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    op_io_chan #(
        .DATA_BITWIDTH  (DW),
        .CH_NUM         (CHN),
        .CH_BITWIDTH    (CHW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_in_req    (op_in_req),
        .op_out_req   (op_out_req),
        .op_ch        (op_ch),
        .op_wdata     (op_wdata),
        .op_rdata     (op_rdata),
        .op_done      (op_done),
        .op_busy      (op_busy),
        .op_err       (op_err),
        .io_in_data   (io_in_data),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_out_data  (io_out_data),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (op_done === 1'b1) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_and_compare(input string name);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb: op_done with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            if ({op_rdata, op_err} !== {e.rdata, e.err}) begin
                n_fail++;
                $display("FAIL %s_result: rdata=%h err=%b, required rdata=%h err=%b",
                         name, op_rdata, op_err, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({op_busy, op_done, op_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/err=%b, required 000", {op_busy, op_done, op_err});
        end
        n_checks++;
        if ({op_rdata, io_out_data} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h out_data=%h, required 00 00", op_rdata, io_out_data);
        end
        n_checks++;
        if ({io_in_ready, io_out_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hs: ready=%b valid=%b, required 0", io_in_ready, io_out_valid);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        io_in_data  = {8'hA5, 8'h77, 8'h66};
        io_in_valid = 3'b111;
        op_ch       = 2'd2;
        op_in_req   = 1'b1;
        sb.push_back('{rdata: 8'hA5, err: 1'b0});
        tick();
        op_in_req = 1'b0;
        n_checks++;
        if ({io_in_ready, op_busy, op_done} !== {3'b100, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL read_wait: ready=%b busy=%b done=%b, required 100 1 0",
                     io_in_ready, op_busy, op_done);
        end
        tick();
        n_checks++;
        if ({op_done, io_in_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL read_done: done=%b ready=%b, required 1 000", op_done, io_in_ready);
        end
        if (op_done === 1'b1) pop_and_compare("read");
        tick();
        n_checks++;
        if ({op_done, op_busy, op_rdata} !== {2'b00, 8'hA5}) begin
            n_fail++;
            $display("FAIL read_after: done=%b busy=%b rdata=%h, required 0 0 a5",
                     op_done, op_busy, op_rdata);
        end
    endtask

    task automatic test_write_backpressure();
        io_out_ready = 3'b101;
        op_ch        = 2'd1;
        op_wdata     = 8'h3C;
        op_out_req   = 1'b1;
        sb.push_back('{rdata: 8'hA5, err: 1'b0});
        tick();
        op_out_req = 1'b0;
        op_wdata   = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({io_out_valid, io_out_data, op_done} !== {3'b010, 8'h3C, 1'b0}) begin
                n_fail++;
                $display("FAIL write_stall%0d: valid=%b data=%h done=%b, required 010 3c 0",
                         i, io_out_valid, io_out_data, op_done);
            end
            tick();
        end
        io_out_ready = 3'b010;
        tick();
        io_out_ready = 3'b000;
        n_checks++;
        if (op_done !== 1'b1) begin
            n_fail++;
            $display("FAIL write_done: done=%b, required 1", op_done);
        end
        if (op_done === 1'b1) pop_and_compare("write");
        tick();
        n_checks++;
        if ({io_out_valid, op_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL write_after: valid=%b busy=%b, required 000 0", io_out_valid, op_busy);
        end
    endtask

    task automatic test_simultaneous();
        int d0;
        logic [CHN-1:0] outv;
        d0   = done_cnt;
        outv = '0;
        io_in_data   = {8'h00, 8'h00, 8'h5A};
        io_in_valid  = 3'b111;
        io_out_ready = 3'b111;
        op_ch        = 2'd0;
        op_wdata     = 8'hC3;
        op_in_req    = 1'b1;
        op_out_req   = 1'b1;
        sb.push_back('{rdata: 8'h5A, err: 1'b0});
        tick();
        outv |= io_out_valid;
        n_checks++;
        if (io_in_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL simul_ready: ready=%b, required 001", io_in_ready);
        end
        tick();
        outv |= io_out_valid;
        op_in_req  = 1'b0;
        op_out_req = 1'b0;
        n_checks++;
        if (op_done !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_done: done=%b, required 1", op_done);
        end
        if (op_done === 1'b1) pop_and_compare("simul");
        for (int i = 0; i < 4; i++) begin
            tick();
            outv |= io_out_valid;
        end
        io_out_ready = 3'b000;
        n_checks++;
        if ({outv, io_out_data} !== {3'b000, 8'h3C}) begin
            n_fail++;
            $display("FAIL simul_no_write: valid_seen=%b out_data=%h, required 000 3c", outv, io_out_data);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL simul_done_count: %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_illegal_ch();
        logic [CHN-1:0] hs;
        hs = '0;
        op_ch     = 2'd3;
        op_in_req = 1'b1;
        sb.push_back('{rdata: 8'h00, err: 1'b1});
        tick();
        op_in_req = 1'b0;
        hs |= io_in_ready | io_out_valid;
        n_checks++;
        if ({op_done, op_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL illegal_rd_done: done=%b busy=%b, required 1 1", op_done, op_busy);
        end
        if (op_done === 1'b1) pop_and_compare("illegal_rd");
        tick();
        hs |= io_in_ready | io_out_valid;
        op_wdata   = 8'hEE;
        op_out_req = 1'b1;
        sb.push_back('{rdata: 8'h00, err: 1'b1});
        tick();
        op_out_req = 1'b0;
        hs |= io_in_ready | io_out_valid;
        n_checks++;
        if ({op_done, io_out_data} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL illegal_wr_done: done=%b out_data=%h, required 1 3c", op_done, io_out_data);
        end
        if (op_done === 1'b1) pop_and_compare("illegal_wr");
        tick();
        hs |= io_in_ready | io_out_valid;
        n_checks++;
        if ({hs, op_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL illegal_no_hs: hs_seen=%b busy=%b, required 000 0", hs, op_busy);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [CHN-1:0] exp_rdy;
        d0 = done_cnt;
        io_in_data  = {8'h12, 8'h11, 8'h10};
        io_in_valid = 3'b111;
        op_in_req   = 1'b1;
        for (int i = 0; i < CHN; i++) begin
            op_ch = CHW'(i);
            exp_rdy = CHN'(1 << i);
            sb.push_back('{rdata: DW'(8'h10 + i), err: 1'b0});
            tick();
            n_checks++;
            if ({io_in_ready, op_done} !== {exp_rdy, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_wait%0d: ready=%b done=%b, required %b 0", i, io_in_ready, op_done, exp_rdy);
            end
            tick();
            n_checks++;
            if (op_done !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_done%0d: done=%b, required 1", i, op_done);
            end
            if (op_done === 1'b1) pop_and_compare("b2b");
            tick();
            n_checks++;
            if (op_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle%0d: busy=%b, required 0", i, op_busy);
            end
        end
        op_in_req = 1'b0;
        tick();
        n_checks++;
        if (done_cnt - d0 != CHN) begin
            n_fail++;
            $display("FAIL b2b_count: %0d pulses, required %0d", done_cnt - d0, CHN);
        end
    endtask

    task automatic test_timeout();
        int d0;
        int cyc;
        io_in_valid = 3'b000;
        op_ch       = 2'd1;
        op_in_req   = 1'b1;
        d0 = done_cnt;
        tick();
        op_in_req = 1'b0;
`ifdef BXU_IO_TIMEOUT_EN
        sb.push_back('{rdata: 8'h00, err: 1'b1});
        cyc = 0;
        while (op_done !== 1'b1 && cyc < 4 * TO) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (op_done !== 1'b1 || cyc != TO) begin
            n_fail++;
            $display("FAIL timeout_latency: done=%b after %0d cycles, required 1 after %0d", op_done, cyc, TO);
        end
        if (op_done === 1'b1) pop_and_compare("timeout");
        tick();
        n_checks++;
        if (op_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: busy=%b, required 0", op_busy);
        end
`else
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            if (op_busy === 1'b1) cyc++;
            tick();
        end
        n_checks++;
        if (cyc != 1000 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL hold_wait: busy %0d of 1000 cycles, %0d done pulses, required 1000 and 0",
                     cyc, done_cnt - d0);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({op_busy, io_in_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL hold_reset: busy=%b ready=%b, required 0 000", op_busy, io_in_ready);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int d0;
        io_out_ready = 3'b000;
        op_ch        = 2'd2;
        op_wdata     = 8'h9D;
        op_out_req   = 1'b1;
        tick();
        op_out_req = 1'b0;
        n_checks++;
        if ({io_out_valid, op_busy} !== 4'b1001) begin
            n_fail++;
            $display("FAIL rstmid_wait: valid=%b busy=%b, required 100 1", io_out_valid, op_busy);
        end
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({io_out_valid, op_busy, op_done, io_out_data} !== {3'b000, 2'b00, 8'h00}) begin
            n_fail++;
            $display("FAIL rstmid_after: valid=%b busy=%b done=%b out_data=%h, required 000 0 0 00",
                     io_out_valid, op_busy, op_done, io_out_data);
        end
        rst_n = 1'b1;
        io_out_ready = 3'b111;
        for (int i = 0; i < 3; i++) tick();
        io_out_ready = 3'b000;
        n_checks++;
        if (done_cnt != d0 || op_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: %0d pulses busy=%b, required 0 0", done_cnt - d0, op_busy);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_backpressure();
        test_simultaneous();
        test_illegal_ch();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
